// File: rtl/phy_tx_sched_pkg.sv
// rtl/phy_tx_sched_pkg.sv - shared PHY TX link constants and scheduler FSM encoding
// Contents:
//   PHY_COM_WORD  : link-init word, four K28.5 symbols
//   PHY_IDLE_WORD : word driven when nothing is being sent
//   sched_state_t : scheduler FSM states (INIT = 0, RUN = 1)
//   sat_inc       : increment that saturates at a limit
package phy_tx_sched_pkg;

    localparam logic [31:0] PHY_COM_WORD  = 32'hBCBC_BCBC;
    localparam logic [31:0] PHY_IDLE_WORD = 32'h7C7C_7C7C;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value >= limit) ? limit : value + 8'd1;
    endfunction

endpackage

// File: rtl/phy_tx_sched_if.sv
// rtl/phy_tx_sched_if.sv - requester and PHY-side signal bundle of the TX scheduler
// Signals:
//   req0_data/req0_valid/req0_ready : requester 0 word handshake
//   req1_data/req1_valid/req1_ready : requester 1 word handshake
//   data_out/valid_out              : word and qualifier towards PHY TX data_in/valid_in
//   init_done                       : high once the link-init sequence has completed
// Modports:
//   master : requester/PHY side (drives requests, observes scheduler outputs)
//   slave  : scheduler side
interface phy_tx_sched_if;

    logic [31:0] req0_data;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req1_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic        init_done;

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid,
        input  req0_ready, req1_ready, data_out, valid_out, init_done
    );

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid,
        output req0_ready, req1_ready, data_out, valid_out, init_done
    );

endinterface

// File: rtl/phy_tx_rr_arb.sv
// rtl/phy_tx_rr_arb.sv - two-way burst-limited grant logic for the PHY TX scheduler
// Ports:
//   clk_2f  : word-rate clock
//   reset   : synchronous active-high reset
//   run     : arbitration enabled (scheduler in RUN and not in reset)
//   valid0  : requester 0 has a word
//   valid1  : requester 1 has a word
//   grant0  : requester 0 granted this cycle (combinational)
//   grant1  : requester 1 granted this cycle (combinational)
module phy_tx_rr_arb
    import phy_tx_sched_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk_2f,
    input  logic reset,
    input  logic run,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    localparam logic [7:0] BURST_LIM = 8'(BURST);

    logic       last;
    logic [7:0] cnt;
    logic       any_grant;
    logic       grantee;

    always_comb begin
        any_grant = run & (valid0 | valid1);
        // Under contention the current owner keeps the link until it has
        // used its burst; a lone requester is always served.
        if (valid0 & valid1) begin
            grantee = (cnt < BURST_LIM) ? last : ~last;
        end else begin
            grantee = valid1;
        end
    end

    assign grant0 = any_grant & ~grantee;
    assign grant1 = any_grant & grantee;

    // A grant is only ever given to a valid requester, so any_grant is
    // exactly the "a transfer happens on this edge" condition.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            last <= 1'b0;
            cnt  <= 8'd0;
        end else if (any_grant) begin
            if (grantee == last) begin
                cnt <= sat_inc(cnt, BURST_LIM);
            end else begin
                last <= grantee;
                cnt  <= 8'd1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_sched.sv
// rtl/phy_tx_sched.sv - PHY TX word scheduler: link-init COM sequence, then two-requester arbitration
// Ports:
//   clk_2f : sole clock, 32-bit word rate of the PHY TX
//   reset  : synchronous active-high reset
//   bus    : phy_tx_sched_if.slave (requester handshakes, data_out/valid_out, init_done)
// After reset the block emits INIT_WORDS COM words, then enters RUN for good and
// forwards requester words through a one-cycle output register.
module phy_tx_sched
    import phy_tx_sched_pkg::*;
#(
    parameter int          INIT_WORDS = 4,
    parameter int          BURST      = 4,
    parameter logic [31:0] COM_WORD   = PHY_COM_WORD,
    parameter logic [31:0] IDLE_WORD  = PHY_IDLE_WORD
) (
    input  logic           clk_2f,
    input  logic           reset,
    phy_tx_sched_if.slave  bus
);

    localparam logic [7:0] INIT_LIM = 8'(INIT_WORDS);

    sched_state_t state;
    logic [7:0]   init_cnt;
    logic [31:0]  data_q;
    logic         valid_q;
    logic         init_done_q;
    logic         run;
    logic         grant0;
    logic         grant1;

    // Readys must read low throughout reset even if the FSM was in RUN.
    assign run = (state == ST_RUN) & ~reset;

    phy_tx_rr_arb #(
        .BURST (BURST)
    ) u_arb (
        .clk_2f (clk_2f),
        .reset  (reset),
        .run    (run),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.init_done  = init_done_q;

    // INIT spends INIT_WORDS edges registering COM words; the edge after the
    // last one lands in RUN with an idle output, so init_done rises on the
    // first cycle in which requesters can be served.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state       <= ST_INIT;
            init_cnt    <= 8'd0;
            data_q      <= IDLE_WORD;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LIM) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                        data_q      <= IDLE_WORD;
                        valid_q     <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 8'd1;
                        data_q   <= COM_WORD;
                        valid_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant0) begin
                        data_q  <= bus.req0_data;
                        valid_q <= 1'b1;
                    end else if (grant1) begin
                        data_q  <= bus.req1_data;
                        valid_q <= 1'b1;
                    end else begin
                        data_q  <= IDLE_WORD;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_sched.sv
// tb/tb_phy_tx_sched.sv - self-checking bench for phy_tx_sched against a cycle-count reference model
module tb_phy_tx_sched;

    localparam int          IW    = 4;
    localparam int          BURST = 4;
    localparam logic [31:0] COM   = 32'hBCBC_BCBC;
    localparam logic [31:0] IDLE  = 32'h7C7C_7C7C;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;

    always #5 clk_2f = ~clk_2f;

    phy_tx_sched_if bus ();

    phy_tx_sched #(
        .INIT_WORDS (IW),
        .BURST      (BURST)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cyc counts cycles since reset release; owner/run_len
    // follow the fairness rule; prev_* hold what was sent on the last edge.
    int          cyc;
    int          owner;
    int          run_len;
    bit          prev_xfer;
    logic [31:0] prev_word;
    int          a_idx;
    int          b_idx;
    logic [31:0] outq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input bit v0, input bit v1);
        logic [31:0] exp_d;
        logic        exp_v;
        int          g;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_data  = 32'hA0 + 32'(a_idx);
        bus.req1_data  = 32'hB0 + 32'(b_idx);
        #1;
        if (cyc == 0) begin
            exp_d = IDLE; exp_v = 1'b0;
        end else if (cyc <= IW) begin
            exp_d = COM;  exp_v = 1'b1;
        end else if (prev_xfer) begin
            exp_d = prev_word; exp_v = 1'b1;
        end else begin
            exp_d = IDLE; exp_v = 1'b0;
        end
        chk("data_out", bus.data_out, exp_d);
        chk("valid_out", 32'(bus.valid_out), 32'(exp_v));
        chk("init_done", 32'(bus.init_done), (cyc > IW) ? 32'd1 : 32'd0);
        g = -1;
        if (cyc > IW) begin
            if (v0 && v1)  g = (run_len < BURST) ? owner : 1 - owner;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        chk("req0_ready", 32'(bus.req0_ready), (g == 0) ? 32'd1 : 32'd0);
        chk("req1_ready", 32'(bus.req1_ready), (g == 1) ? 32'd1 : 32'd0);
        if (cyc > IW && bus.valid_out === 1'b1) outq.push_back(bus.data_out);
        @(posedge clk_2f);
        prev_xfer = (g >= 0);
        if (g == 0) begin prev_word = 32'hA0 + 32'(a_idx); a_idx++; end
        if (g == 1) begin prev_word = 32'hB0 + 32'(b_idx); b_idx++; end
        if (g >= 0) begin
            if (g == owner) run_len = (run_len + 1 > BURST) ? BURST : run_len + 1;
            else begin owner = g; run_len = 1; end
        end
        cyc++;
        @(negedge clk_2f);
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            @(posedge clk_2f);
            @(negedge clk_2f);
            chk("rst_data", bus.data_out, IDLE);
            chk("rst_valid", 32'(bus.valid_out), 32'd0);
            chk("rst_init_done", 32'(bus.init_done), 32'd0);
        end
        reset     = 1'b0;
        cyc       = 0;
        owner     = 0;
        run_len   = 0;
        prev_xfer = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        int          grp;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        a_idx = 0;
        b_idx = 0;

        // Reset for two cycles, no requesters: COM words, then idle RUN.
        do_reset(2);
        for (int i = 0; i < IW + 3; i++) step(1'b0, 1'b0);

        // req0 waiting through INIT is held off until RUN.
        do_reset(1);
        for (int i = 0; i < IW + 4; i++) step(1'b1, 1'b0);

        // Both continuously valid: bursts of BURST words alternate.
        do_reset(1);
        for (int i = 0; i < IW + 1; i++) step(1'b0, 1'b0);
        a_idx = 0;
        b_idx = 0;
        outq.delete();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1);
        chk("burst_count", 32'(outq.size()), 32'd12);
        for (int k = 0; k < 12 && k < outq.size(); k++) begin
            grp   = k / 4;
            exp_w = ((grp % 2 == 0) ? 32'hA0 : 32'hB0) + 32'((grp / 2) * 4 + k % 4);
            chk("burst_order", outq[k], exp_w);
        end

        // Only req1 valid: no burst limit without contention.
        step(1'b0, 1'b0);
        outq.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("solo_count", 32'(outq.size()), 32'd10);
        for (int k = 1; k < outq.size(); k++)
            chk("solo_order", outq[k], outq[0] + 32'(k));

        // req0 sends two words then drops; req1 takes over immediately.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

        // Reset in the middle of a burst replays INIT.
        step(1'b1, 1'b1);
        do_reset(1);
        for (int i = 0; i < IW + 6; i++) step(1'b1, 1'b1);

        // Random valids with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
